// File: rtl/aes_key_expand_if.sv
// Stream and control bundle between the key schedule and the round datapath.
// Optional key-store read port appears when AES_KEY_STORE_EN is defined.
interface aes_key_expand_if;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         done;
`ifdef AES_KEY_STORE_EN
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
`endif

  modport master (
`ifdef AES_KEY_STORE_EN
    output rd_idx,
    input  rd_key,
`endif
    output start, key_in, rk_ready,
    input  busy, rk_valid, round_key, round_idx, done
  );

  modport slave (
`ifdef AES_KEY_STORE_EN
    input  rd_idx,
    output rd_key,
`endif
    input  start, key_in, rk_ready,
    output busy, rk_valid, round_key, round_idx, done
  );
endinterface

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per accepted beat, rounds 0..10.
// Define AES_KEY_STORE_EN to add an 11-entry round-key file with a read port.
module sbox_lane #(
  parameter bit EN = 1'b1
) (
  input  logic [7:0] i_b,
  output logic [7:0] o_b
);
  localparam logic [0:255][7:0] SBOX = {
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  assign o_b = EN ? SBOX[i_b] : 8'h00;
endmodule

// NUM parallel forward S-box lanes; EN=0 forces every lane output to zero.
module sbox #(
  parameter int NUM = 4,
  parameter bit EN  = 1'b1
) (
  input  logic [NUM-1:0][7:0] i_b,
  output logic [NUM-1:0][7:0] o_b
);
  for (genvar g = 0; g < NUM; g++) begin : g_lane
    sbox_lane #(.EN(EN)) u_lane (.i_b(i_b[g]), .o_b(o_b[g]));
  end
endmodule

module aes_key_expand #(
  parameter logic [7:0] RCON_INIT = 8'h01
) (
  input logic              clk,
  input logic              rst_n,
  aes_key_expand_if.slave  bus
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t       r_state;
  logic         r_busy, r_valid, r_done;
  logic [127:0] r_key;
  logic [3:0]   r_idx;
  logic [7:0]   r_rcon;

  logic [3:0][7:0] w_rot, w_sub;
  logic [31:0]     w_t, w_w4, w_w5, w_w6, w_w7;
  logic [127:0]    w_next;
  logic [7:0]      w_xtime;
  logic            w_acc;

  assign w_acc   = r_valid & bus.rk_ready;
  assign w_rot   = {r_key[23:0], r_key[31:24]};
  assign w_t     = w_sub ^ {r_rcon, 24'h0};
  assign w_w4    = r_key[127:96] ^ w_t;
  assign w_w5    = w_w4 ^ r_key[95:64];
  assign w_w6    = w_w5 ^ r_key[63:32];
  assign w_w7    = w_w6 ^ r_key[31:0];
  assign w_next  = {w_w4, w_w5, w_w6, w_w7};
  assign w_xtime = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

  sbox #(.NUM(4), .EN(1'b1)) u_sbox (.i_b(w_rot), .o_b(w_sub));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_key   <= '0;
      r_idx   <= '0;
      r_rcon  <= RCON_INIT;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (bus.start) begin
          r_state <= RUN;
          r_busy  <= 1'b1;
          r_valid <= 1'b1;
          r_key   <= bus.key_in;
          r_idx   <= '0;
          r_rcon  <= RCON_INIT;
        end
        RUN: if (w_acc) begin
          if (r_idx == 4'd10) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_key  <= w_next;
            r_idx  <= r_idx + 4'd1;
            r_rcon <= w_xtime;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.rk_valid  = r_valid;
  assign bus.round_key = r_key;
  assign bus.round_idx = r_idx;
  assign bus.done      = r_done;

`ifdef AES_KEY_STORE_EN
  logic [127:0] r_store [0:10];

  // Entries survive a new start; each is overwritten only when its beat is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 11; i++) r_store[i] <= '0;
    end else if (w_acc && r_idx <= 4'd10) begin
      r_store[r_idx] <= r_key;
    end
  end

  always_comb begin
    bus.rd_key = '0;
    if (bus.rd_idx <= 4'd10) bus.rd_key = r_store[bus.rd_idx];
  end
`endif
endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand: FIPS-197 and zero-key schedules, stalls, resets.
module tb_aes_key_expand;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  aes_key_expand_if bus();

  aes_key_expand dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
    bit           chk;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  logic [127:0] fips_rk [0:10];
  logic [127:0] z1, z10;

  initial begin
    fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    z1  = 128'h62636363626363636263636362636363;
    z10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  end

  task automatic push_fips();
    for (int i = 0; i < 11; i++) sb.push_back('{i[3:0], fips_rk[i], 1'b1});
  endtask

  task automatic push_zero();
    for (int i = 0; i < 11; i++) begin
      exp_t e;
      e.idx = i[3:0];
      e.chk = (i == 0 || i == 1 || i == 10);
      e.key = (i == 1) ? z1 : (i == 10) ? z10 : '0;
      sb.push_back(e);
    end
  endtask

  // Pulse start at a negedge; returns at the negedge where round 0 should be visible.
  task automatic kick(input logic [127:0] key);
    bus.start  = 1'b1;
    bus.key_in = key;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.key_in = '0;
  endtask

  // Consume the stream against the scoreboard; returns at the negedge where done should show.
  task automatic stream(input bit rnd, input int inj_idx, output int cycles);
    bit           stalled = 1'b0;
    bit           injected = 1'b0;
    logic [127:0] pk = '0;
    logic [3:0]   pi = '0;
    cycles = 0;
    while (sb.size() > 0 && cycles < 400) begin
      if (!bus.rk_valid) begin
        n_tests++; n_fail++;
        $display("FAIL stream_valid: rk_valid=%b required 1 (pending %0d)", bus.rk_valid, sb.size());
        sb.delete();
        break;
      end
      if (stalled) begin
        n_tests++;
        if (bus.round_key !== pk || bus.round_idx !== pi) begin
          n_fail++;
          $display("FAIL stall_hold: key=%h idx=%0d required key=%h idx=%0d", bus.round_key, bus.round_idx, pk, pi);
        end
      end
      if (inj_idx >= 0 && !injected && bus.round_idx == inj_idx[3:0]) begin
        bus.start = 1'b1; bus.key_in = '0; injected = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      bus.rk_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (bus.rk_ready) begin
        exp_t e = sb.pop_front();
        n_tests++;
        if (bus.round_idx !== e.idx) begin
          n_fail++;
          $display("FAIL round_idx: got %0d required %0d", bus.round_idx, e.idx);
        end
        if (e.chk) begin
          n_tests++;
          if (bus.round_key !== e.key) begin
            n_fail++;
            $display("FAIL round_key[%0d]: got %h required %h", e.idx, bus.round_key, e.key);
          end
        end
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        pk = bus.round_key;
        pi = bus.round_idx;
      end
      @(negedge clk);
      cycles++;
    end
    bus.start = 1'b0;
    n_tests++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.rk_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL end_of_run: done=%b busy=%b valid=%b required 1 0 0", bus.done, bus.busy, bus.rk_valid);
    end
  endtask

  task automatic test_reset();
    #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.rk_valid !== 1'b0 || bus.done !== 1'b0 ||
        bus.round_key !== '0 || bus.round_idx !== '0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b valid=%b done=%b key=%h idx=%0d required all 0",
               bus.busy, bus.rk_valid, bus.done, bus.round_key, bus.round_idx);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b0 || bus.rk_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold: busy=%b valid=%b required 0 0", bus.busy, bus.rk_valid);
    end
  endtask

  task automatic test_fips();
    int cyc;
    push_fips();
    kick(FIPS_KEY);
    n_tests++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_after_start: got %b required 1", bus.busy);
    end
    stream(1'b0, -1, cyc);
    n_tests++;
    if (cyc !== 11) begin
      n_fail++;
      $display("FAIL fips_latency: done after %0d cycles required 11", cyc);
    end
    @(negedge clk);
    n_tests++;
    if (bus.done !== 1'b0 || bus.round_idx !== 4'd10 || bus.round_key !== fips_rk[10]) begin
      n_fail++;
      $display("FAIL post_done: done=%b idx=%0d key=%h required 0 10 %h", bus.done, bus.round_idx, bus.round_key, fips_rk[10]);
    end
  endtask

  task automatic test_zero_key();
    int cyc;
    push_zero();
    kick('0);
    stream(1'b0, -1, cyc);
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int cyc;
    push_fips();
    kick(FIPS_KEY);
    stream(1'b1, -1, cyc);
    bus.rk_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_start_while_busy();
    int cyc;
    push_fips();
    kick(FIPS_KEY);
    stream(1'b0, 4, cyc);
    n_tests++;
    if (cyc !== 11) begin
      n_fail++;
      $display("FAIL start_ignored_len: %0d cycles required 11", cyc);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc;
    push_fips();
    kick(FIPS_KEY);
    stream(1'b0, -1, cyc);
    push_zero();
    kick('0);
    stream(1'b0, -1, cyc);
    n_tests++;
    if (cyc !== 11) begin
      n_fail++;
      $display("FAIL b2b_len: %0d cycles required 11", cyc);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    int dones = 0;
    kick(FIPS_KEY);
    bus.rk_ready = 1'b1;
    while (bus.round_idx != 4'd6 && cyc < 50) begin
      @(negedge clk); cyc++;
    end
    n_tests++;
    if (bus.round_idx !== 4'd6) begin
      n_fail++;
      $display("FAIL reach_round6: idx=%0d required 6", bus.round_idx);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.rk_valid !== 1'b0 || bus.round_key !== '0 || bus.round_idx !== '0) begin
      n_fail++;
      $display("FAIL async_reset: busy=%b valid=%b key=%h idx=%0d required all 0",
               bus.busy, bus.rk_valid, bus.round_key, bus.round_idx);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
      if (i == 1) rst_n = 1'b1;
    end
    n_tests++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL no_done_on_abort: %0d done pulses required 0", dones);
    end
    push_fips();
    kick(FIPS_KEY);
    stream(1'b0, -1, cyc);
    @(negedge clk);
  endtask

`ifdef AES_KEY_STORE_EN
  task automatic test_key_store();
    logic [3:0]   ids [0:3];
    logic [127:0] exp;
    ids[0] = 4'd0; ids[1] = 4'd10; ids[2] = 4'd15; ids[3] = 4'd5;
    for (int i = 0; i < 4; i++) begin
      bus.rd_idx = ids[i];
      exp = (ids[i] <= 4'd10) ? fips_rk[ids[i]] : '0;
      #1;
      n_tests++;
      if (bus.rd_key !== exp) begin
        n_fail++;
        $display("FAIL rd_key[%0d]: got %h required %h", ids[i], bus.rd_key, exp);
      end
    end
  endtask
`endif

  initial begin
    bus.start    = 1'b0;
    bus.key_in   = '0;
    bus.rk_ready = 1'b1;
`ifdef AES_KEY_STORE_EN
    bus.rd_idx   = '0;
`endif
    test_reset();
    test_fips();
    test_zero_key();
    test_backpressure();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
`ifdef AES_KEY_STORE_EN
    test_key_store();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
